mux_4_1_rr_arbiter: RTL and testbench
=====================================

# mux_4_1_rr_arbiter

Round-robin arbiter that shares one 4:1 data mux between four requesters using valid/ready handshakes, with burst locking. It drives the mux select from the current grant and registers the selected beat into a single-entry output stage. It sits between four producers and one consumer of the shared narrow datapath.

## Interface
- WIDTH, 4, data width of each requester and of the output.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  bit i: requester i presents a beat.
- in_last  input  4  bit i: the beat from requester i ends its burst.
- d0, d1, d2, d3  input  WIDTH each  requester data.
- in_ready  output  4  bit i: the beat from requester i is accepted this cycle. One-hot or zero.
- out_valid  output  1  the output register holds a beat.
- out_ready  input  1  the consumer accepts the output beat.
- y  output  WIDTH  registered output data.
- out_src  output  2  index of the requester that produced y.
- out_last  output  1  registered copy of in_last for that beat.

## Operation
- slot_free = !out_valid || out_ready.
- A beat from requester i transfers when in_valid[i] && in_ready[i].
- State register `state`:
  - IDLE: no burst is in progress.
  - LOCKED: a burst is in progress. Register `owner` (2 bits) holds the locked requester.
- Priority pointer `last_grant` (2 bits) holds the requester that most recently finished a burst.
- IDLE:
  - Search in_valid starting at last_grant+1 (mod 4), upward with wrap-around. The first set bit is the winner.
  - If any in_valid is set and slot_free is true, in_ready[winner]=1 and the winner's beat is accepted.
  - If the accepted beat has in_last=1: stay in IDLE and set last_grant=winner.
  - If the accepted beat has in_last=0: go to LOCKED with owner=winner.
- LOCKED:
  - in_ready[owner] = slot_free. All other in_ready bits are 0, regardless of their valid.
  - When the owner's beat is accepted with in_last=1: go to IDLE and set last_grant=owner.
  - While in_valid[owner]=0, the lock holds and no other requester is served. Bubbles are allowed.
- Mux select:
  - sel = winner in IDLE, sel = owner in LOCKED.
  - The selected dN feeds the output register. The select uses the 4:1 mux from our mux library.
- Output register, on a transfer:
  - y <= selected data, out_src <= sel, out_last <= the selected in_last, out_valid <= 1.
  - Otherwise, if out_ready is high, out_valid <= 0.
  - y, out_src and out_last hold their values when there is no transfer.
- in_ready depends combinationally on in_valid, out_ready and state. It never depends on in_ready itself, so there is no combinational loop.
- Requesters must keep in_valid and data stable until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - out_valid=0, y=0, out_src=0, out_last=0.
  - state=IDLE, owner=0, last_grant=3, so requester 0 has first priority.
  - in_ready=0 while rst_n=0.
- Latency: a beat accepted in cycle t appears on y with out_valid=1 in cycle t+1.
- Throughput: one beat per cycle while out_ready=1.
- When out_valid=1 and out_ready=1, a new beat can load in the same cycle (back-to-back transfers).
- Backpressure: when out_ready=0 and out_valid=1, all in_ready bits are 0 and the output holds.
- The arbitration decision and grant take effect in the same cycle as the request. The pointer update is visible in the next cycle.
- Single-beat requests (in_last=1) rotate priority on every transfer. With all four requesters active the grant order is 0,1,2,3,0,...
- Reset asserted mid-burst:
  - Takes effect immediately: the output clears, the lock is dropped and the pointer goes back to 3.
  - Partial bursts are not resumed.
- When only the owner is valid, ownership is unchanged. Non-owners wait until the owner's last beat is accepted.

## Test plan
- Reset, then all four requesters valid with in_last=1 and d0..d3=A,B,C,D, out_ready=1. Required:
  - in_ready is 0001, 0010, 0100, 1000 on consecutive cycles.
  - y is A,B,C,D starting one cycle later.
  - out_src is 0,1,2,3.
- Requester 2 sends a 3-beat burst (5,6,7, last on 7) while requester 0 is continuously valid with 9. Required:
  - y=5,6,7 with out_src=2, then 9 with out_src=0.
  - in_ready[0] stays 0 during the burst.
- Backpressure: hold out_ready=0 for 3 cycles with requester 1 valid, data 3. Required:
  - out_valid=1 and y=3 hold.
  - in_ready=0000 for those cycles.
  - The next beat loads in the cycle out_ready returns to 1.
- Owner bubble: requester 3 starts a burst, drops in_valid for 2 cycles, then sends its last beat, while requester 1 is valid throughout. Required:
  - in_ready[1] stays 0 until the cycle after requester 3's last beat is accepted.
- Reset mid-burst: assert rst_n=0 during a requester 1 burst, then release with requesters 0 and 1 valid. Required:
  - out_valid=0 immediately after reset asserts.
  - The first grant after release goes to requester 0.
- Pointer wrap: after requester 3's single beat, requesters 0 and 3 are valid. Required: the grant goes to requester 0.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four valid/ready
// requesters, with burst locking and a single-entry registered output.
//
// mux_4_1 ports:
//   sel   in  [1:0]        select
//   d0-d3 in  [WIDTH-1:0]  data inputs
//   y     out [WIDTH-1:0]  selected data
//
// mux_4_1_rr_arbiter ports:
//   clk, rst_n  in   clock, async active-low reset
//   in_valid    in   [3:0]        per-requester beat present
//   in_last     in   [3:0]        per-requester end of burst
//   d0-d3       in   [WIDTH-1:0]  per-requester data
//   in_ready    out  [3:0]        per-requester accept (one-hot or zero)
//   out_valid   out               output register holds a beat
//   out_ready   in                consumer accepts the output beat
//   y           out  [WIDTH-1:0]  registered data
//   out_src     out  [1:0]        requester that produced y
//   out_last    out               registered in_last of that beat

module mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux_4_1_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       out_src,
    output logic             out_last
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] last_grant, last_grant_n;

    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic [1:0]       sel;
    logic             grant;
    logic             slot_free;
    logic             xfer;
    logic             sel_last;
    logic [WIDTH-1:0] mux_y;

    assign slot_free = !out_valid || out_ready;

    // Rotating search: start just above the last finished burst, so
    // k=4 wraps back onto last_grant itself as the lowest priority.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // A locked owner is offered the slot even while it bubbles.
    always_comb begin
        sel   = winner;
        grant = 1'b0;
        unique case (state)
            IDLE: begin
                sel   = winner;
                grant = found && slot_free;
            end
            LOCKED: begin
                sel   = owner;
                grant = slot_free;
            end
            default: begin
                sel   = winner;
                grant = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && grant)
            in_ready[sel] = 1'b1;
    end

    assign xfer     = |(in_valid & in_ready);
    assign sel_last = in_last[sel];

    mux_4_1 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (mux_y)
    );

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        last_grant_n = sel;
                    end else begin
                        state_n = LOCKED;
                        owner_n = sel;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_n      = IDLE;
                    last_grant_n = owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_src   <= 2'd0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            y         <= mux_y;
            out_src   <= sel;
            out_last  <= sel_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter: hand-computed expected beats
// are queued by the driver and popped by an independent output monitor.
module tb_mux_4_1_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic [1:0] out_src;
    logic       out_last;

    int n_chk  = 0;
    int n_fail = 0;

    // {src, last, data}
    logic [6:0] exp_q[$];

    mux_4_1_rr_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_src   (out_src),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic lst,
                        input logic [3:0] dat);
        exp_q.push_back({src, lst, dat});
    endtask

    // Advance one cycle, drive inputs, then check in_ready mid-cycle.
    task automatic cyc(input logic rs, input logic [3:0] v,
                       input logic [3:0] l, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] e, input logic ordy,
                       input logic [3:0] exp_rdy, input string nm);
        @(posedge clk);
        #1;
        rst_n     = rs;
        in_valid  = v;
        in_last   = l;
        d0        = a;
        d1        = b;
        d2        = c;
        d3        = e;
        out_ready = ordy;
        @(negedge clk);
        check(nm, 8'(in_ready), 8'(exp_rdy));
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat: got src=%0d last=%0d y=%h, expected none",
                         out_src, out_last, y);
            end else begin
                e = exp_q.pop_front();
                if ({out_src, out_last, y} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got src=%0d last=%0d y=%h, expected src=%0d last=%0d y=%h",
                             out_src, out_last, y, e[6:5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
        out_ready = 1'b1;
        #2 rst_n  = 1'b0;

        cyc(0, 4'b1111, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, "rst_ready");
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_y", 8'(y), 8'd0);
        check("rst_out_src", 8'(out_src), 8'd0);
        check("rst_out_last", 8'(out_last), 8'd0);

        // All four single-beat requesters: rotate 0,1,2,3.
        push(0, 1, 4'hA); push(1, 1, 4'hB);
        push(2, 1, 4'hC); push(3, 1, 4'hD);
        cyc(1, 4'b1111, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0001, "rr0");
        cyc(1, 4'b1111, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0010, "rr1");
        cyc(1, 4'b1111, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b0100, "rr2");
        cyc(1, 4'b1111, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 1, 4'b1000, "rr3");

        // Requester 2 burst 5,6,7 locks out requester 0.
        push(2, 0, 4'h5); push(2, 0, 4'h6);
        push(2, 1, 4'h7); push(0, 1, 4'h9);
        cyc(1, 4'b0100, 4'b0000, 0, 0, 4'h5, 0, 1, 4'b0100, "burst0");
        cyc(1, 4'b0101, 4'b0001, 4'h9, 0, 4'h6, 0, 1, 4'b0100, "burst1");
        cyc(1, 4'b0101, 4'b0101, 4'h9, 0, 4'h7, 0, 1, 4'b0100, "burst2");
        cyc(1, 4'b0001, 4'b0001, 4'h9, 0, 0, 0, 1, 4'b0001, "burst3");

        // Backpressure with requester 1.
        push(1, 1, 4'h3); push(1, 1, 4'h4);
        cyc(1, 4'b0010, 4'b0010, 0, 4'h3, 0, 0, 1, 4'b0010, "bp0");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b0010, 4'b0010, 0, 4'h4, 0, 0, 0, 4'b0000, "bp_hold");
            check("bp_out_valid", 8'(out_valid), 8'd1);
            check("bp_y", 8'(y), 8'h3);
        end
        cyc(1, 4'b0010, 4'b0010, 0, 4'h4, 0, 0, 1, 4'b0010, "bp_release");

        // Owner 3 bubbles for two cycles; requester 1 must wait.
        push(3, 0, 4'hE); push(3, 1, 4'hF); push(1, 1, 4'h1);
        cyc(1, 4'b1010, 4'b0010, 0, 4'h1, 0, 4'hE, 1, 4'b1000, "bub0");
        cyc(1, 4'b0010, 4'b0010, 0, 4'h1, 0, 0, 1, 4'b1000, "bub1");
        cyc(1, 4'b0010, 4'b0010, 0, 4'h1, 0, 0, 1, 4'b1000, "bub2");
        cyc(1, 4'b1010, 4'b1010, 0, 4'h1, 0, 4'hF, 1, 4'b1000, "bub3");
        cyc(1, 4'b0010, 4'b0010, 0, 4'h1, 0, 0, 1, 4'b0010, "bub4");

        // Reset during a requester 1 burst; the second beat is discarded.
        push(1, 0, 4'h2);
        cyc(1, 4'b0010, 4'b0000, 0, 4'h2, 0, 0, 1, 4'b0010, "rb0");
        cyc(1, 4'b0010, 4'b0000, 0, 4'h3, 0, 0, 1, 4'b0010, "rb1");
        cyc(0, 4'b0011, 4'b0011, 4'h7, 4'h8, 0, 0, 1, 4'b0000, "rb_rst");
        check("rb_out_valid", 8'(out_valid), 8'd0);
        push(0, 1, 4'h7); push(1, 1, 4'h8);
        cyc(1, 4'b0011, 4'b0011, 4'h7, 4'h8, 0, 0, 1, 4'b0001, "rb2");
        cyc(1, 4'b0010, 4'b0011, 4'h7, 4'h8, 0, 0, 1, 4'b0010, "rb3");

        // Pointer wrap from 3 back to 0.
        push(3, 1, 4'hC); push(0, 1, 4'h5); push(3, 1, 4'h6);
        cyc(1, 4'b1000, 4'b1000, 0, 0, 0, 4'hC, 1, 4'b1000, "wrap0");
        cyc(1, 4'b1001, 4'b1001, 4'h5, 0, 0, 4'h6, 1, 4'b0001, "wrap1");
        cyc(1, 4'b1000, 4'b1000, 0, 0, 0, 4'h6, 1, 4'b1000, "wrap2");

        cyc(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, "idle0");
        cyc(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, "idle1");
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
